// File: rtl/matrix_frame_scanner.sv
// Double-buffered pixel framebuffer with a row-multiplexed matrix scanner.
// Pixels are written into a back buffer by (x, y). A requested swap copies the
// back buffer to the front buffer only at the end of a frame, so the displayed
// image never tears. The front buffer is scanned one row at a time.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   clear         zero the whole back buffer (a same-cycle write still lands)
//   wr_en/x/y/val single-pixel write into the back buffer
//   swap_req      request a back->front copy at the next frame boundary
//   row_sel       one-hot active-high row drive (registered)
//   col_data      front-buffer pixels of the selected row (registered)
//   frame_start   one-cycle pulse when row 0 becomes selected
//   swap_pending  a swap is requested but not yet taken
//   swap_done     one-cycle pulse when the new front frame is first displayed
//   wr_err        one-cycle pulse after a write with an out-of-range coordinate
module matrix_frame_scanner #(
   parameter int unsigned COLS     = 8,
   parameter int unsigned ROWS     = 8,
   parameter int unsigned SCAN_DIV = 1000,
   localparam int unsigned XW      = $clog2(COLS),
   localparam int unsigned YW      = $clog2(ROWS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clear,
   input  logic            wr_en,
   input  logic [XW-1:0]   wr_x,
   input  logic [YW-1:0]   wr_y,
   input  logic            wr_val,
   input  logic            swap_req,
   output logic [ROWS-1:0] row_sel,
   output logic [COLS-1:0] col_data,
   output logic            frame_start,
   output logic            swap_pending,
   output logic            swap_done,
   output logic            wr_err
);

   localparam int unsigned DW = $clog2(SCAN_DIV);

   typedef enum logic {
      S_IDLE,
      S_PENDING
   } state_t;

   state_t                     state;
   state_t                     state_nxt;
   logic                       take_swap;

   logic [DW-1:0]              div;
   logic [YW-1:0]              row;
   logic [YW-1:0]              row_adv;
   logic                       row_end;
   logic                       frame_end;

   logic [ROWS-1:0][COLS-1:0]  back;
   logic [ROWS-1:0][COLS-1:0]  front;
   logic [ROWS-1:0][COLS-1:0]  disp_src;

   logic                       x_ok;
   logic                       y_ok;
   logic                       wr_ok;

   // Coordinate range checks only exist for non-power-of-two dimensions.
   if (COLS == (32'd1 << XW)) begin : g_x_full
      assign x_ok = 1'b1;
   end else begin : g_x_part
      assign x_ok = (wr_x < XW'(COLS));
   end

   if (ROWS == (32'd1 << YW)) begin : g_y_full
      assign y_ok = 1'b1;
   end else begin : g_y_part
      assign y_ok = (wr_y < YW'(ROWS));
   end

   assign wr_ok     = wr_en && x_ok && y_ok;

   // Scan timing decode.
   assign row_end   = (div == DW'(SCAN_DIV - 1));
   assign frame_end = row_end && (row == YW'(ROWS - 1));
   assign row_adv   = (row == YW'(ROWS - 1)) ? '0 : row + YW'(1);

   // On a taken swap the first row of the new frame comes straight from back.
   assign disp_src  = take_swap ? back : front;

   assign swap_pending = (state == S_PENDING);

   // Swap FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Swap FSM next state; a request landing on the frame-end cycle is taken at once.
   always_comb begin
      state_nxt = state;
      take_swap = 1'b0;
      case (state)
         S_IDLE: begin
            if (swap_req) begin
               if (frame_end) begin
                  take_swap = 1'b1;
               end else begin
                  state_nxt = S_PENDING;
               end
            end
         end
         S_PENDING: begin
            if (frame_end) begin
               take_swap = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Scan counters, display registers, buffers and status pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         div         <= '0;
         row         <= '0;
         back        <= '0;
         front       <= '0;
         row_sel     <= ROWS'(1);
         col_data    <= '0;
         frame_start <= 1'b0;
         swap_done   <= 1'b0;
         wr_err      <= 1'b0;
      end else begin
         frame_start <= frame_end;
         swap_done   <= take_swap;
         wr_err      <= wr_en && !wr_ok;

         if (row_end) begin
            div      <= '0;
            row      <= row_adv;
            row_sel  <= ROWS'(1) << row_adv;
            col_data <= disp_src[row_adv];
         end else begin
            div      <= div + DW'(1);
         end

         // Snapshot uses the pre-edge back; same-edge clear/write affect back only.
         if (take_swap) begin
            front <= back;
         end

         // Clear first, then the write, so a same-cycle write survives.
         if (clear) begin
            back <= '0;
         end
         if (wr_ok) begin
            back[wr_y][wr_x] <= wr_val;
         end
      end
   end

endmodule
